hex_display_ctrl: RTL and testbench
===================================

Name: hex_display_ctrl

Overview:
- Registered, parametrised controller for an N-digit 7-segment bank; successor to the fixed six-digit combinational message decoder.
- Holds a loadable message buffer and shows it static or scrolling. Alternatively shows a VAL_W-bit value in hex, with optional leading-zero blanking and whole-display blink.
- Sits between the memory-controller FSM / debug logic and the board HEX pins.

Parameters:
- NUM_DIGITS, 6, number of physical digits; digit NUM_DIGITS-1 is leftmost.
- MSG_LEN, 16, message buffer depth in characters (must be ≥ 1).
- VAL_W, 16, width of the value shown in hex modes.
- SCROLL_DIV, 25000000, clk cycles per scroll step (≥ 1).
- BLINK_DIV, 12500000, clk cycles per blink half-period (≥ 1).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- mode  in  2  0 = TEXT, 1 = SCROLL, 2 = HEX.
  - Value 3 behaves as HEX with lz_blank forced to 1.
- load  in  1  single-cycle strobe that captures msg_in and msg_len_in.
- msg_in  in  5*MSG_LEN  character codes; char 0 in bits [4:0] is displayed leftmost.
- msg_len_in  in  $clog2(MSG_LEN+1)  number of valid characters.
- val_in  in  VAL_W  value for the HEX modes; sampled every cycle.
- lz_blank  in  1  blank leading zero nibbles in HEX mode.
- blink_en  in  1  enable whole-display blink.
- scroll_wrap  out  1  one-cycle pulse when the scroll position wraps to 0.
- hex_out  out  8*NUM_DIGITS  active-low segments; digit k occupies [8k+7:8k]; bit 7 = DP, bits 6..0 = g..a.

Behaviour:
- Character codes and segment patterns:
  - 0–15 hex: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E.
  - 16 r = AF, 17 d = A1, 18 t = 87, 19 _ = F7, 20 - = BF, 21 n = AB, 22 . = 7F, 23 L = C7, 24 U = C1, 25 blank = FF.
  - Codes 26–31 decode as blank (FF).
- Reset (async assert): outputs and internal state take these values.
  - hex_out = all FF; scroll_wrap = 0.
  - Buffer filled with blank (25); len = 0; pos = 0.
  - Scroll counter = 0; blink counter = 0; blink phase = 0.
- Latency:
  - hex_out is registered and reflects inputs/state sampled on the previous clk edge (1 cycle).
  - A load on edge n becomes visible on hex_out after edge n+1.
- Load:
  - On an edge with load = 1, buffer ← msg_in and len ← min(msg_len_in, MSG_LEN).
  - pos and the scroll counter are cleared on the same edge.
- TEXT mode:
  - Leftmost digit shows buf[0], the next digit buf[1], and so on.
  - Digit positions with index ≥ len show blank; characters beyond NUM_DIGITS are not shown.
- SCROLL mode:
  - Ring length R = len + NUM_DIGITS. Leftmost digit shows index pos, the digit to its right pos+1, and so on, each taken mod R.
  - Any index ≥ len shows blank, which gives a NUM_DIGITS-blank gap between repeats.
  - The scroll counter counts 0..SCROLL_DIV-1. At terminal count, pos ← (pos == R-1) ? 0 : pos+1.
  - scroll_wrap = 1 for exactly the cycle after pos wraps.
  - If len ≤ NUM_DIGITS: no scrolling; the display is identical to TEXT; counter and pos are held at 0; scroll_wrap stays 0.
- HEX mode:
  - Digit k, for k < ceil(VAL_W/4), shows nibble k of val_in (zero-extended); higher digits are blank.
  - With lz_blank: every zero nibble above the most significant nonzero nibble is blanked. Digit 0 always shows, so value 0 displays as "0".
- Mode change: any edge where mode differs from its previous registered value clears pos and the scroll counter.
- Load and mode change on the same edge: both take effect; pos = 0.
- Blink:
  - While blink_en = 1, the blink counter counts 0..BLINK_DIV-1 and the phase toggles at terminal count.
  - While phase = 1, hex_out = all FF.
  - When blink_en = 0, counter and phase are held at 0.
  - Blink does not stall scrolling.
- Reset mid-scroll or mid-blink returns every register to its reset value immediately.

Test Plan:
- NUM_DIGITS=6; load "rEAd_0" (16,14,10,17,19,0), len 6, mode 0 → hex_out = AF_86_88_A1_F7_C0 (digit5..0), appearing one cycle after the load edge.
- Mode 0; load len 3 "t,n,1"; then load with msg_len_in = 20 (> MSG_LEN) → first load gives digits 5..3 = 87,AB,F9 and digits 2..0 = FF; second load leaves len = MSG_LEN and shows six characters.
- SCROLL_DIV=4, mode 1, len 8 "0..7" → leftmost digit steps 0,1,2,…,13 every 4 cycles, then wraps to 0; scroll_wrap pulses once per 56 cycles; at pos 8 all digits are FF.
- Mode 2, VAL_W=16, val 0x00A5 → with lz_blank = 0: 4 digits C0,C0,88,92 and digits 5..4 = FF; with lz_blank = 1: only 88,92, rest FF; val 0 with lz_blank = 1 → only digit 0 = C0.
- BLINK_DIV=3, blink_en = 1 in HEX mode → hex_out alternates valid / all-FF every 3 cycles; drop blink_en → valid on the next cycle with phase 0.
- Assert rst mid-scroll at pos 5 with blink phase 1 → hex_out all FF, pos 0, scroll_wrap 0 asynchronously; after release, mode 0 shows blank until a load.

Source files
------------

// File: rtl/hex_display_ctrl.sv
// rtl/hex_display_ctrl.sv - registered N-digit 7-segment controller (text, scroll, hex, blink)
//
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   mode          0 TEXT, 1 SCROLL, 2 HEX, 3 HEX with leading-zero blanking
//   load          one-cycle strobe capturing msg_in / msg_len_in
//   msg_in        5-bit character codes, char 0 in [4:0] shown leftmost
//   msg_len_in    number of valid characters (clamped to MSG_LEN)
//   val_in        value shown in the HEX modes
//   lz_blank      blank leading zero nibbles in HEX mode
//   blink_en      whole-display blink
//   scroll_wrap   one-cycle pulse after the scroll position wraps to 0
//   hex_out       active-low segments, digit k in [8k+7:8k], bit 7 = DP
module hex_display_ctrl #(
    parameter int NUM_DIGITS = 6,
    parameter int MSG_LEN    = 16,
    parameter int VAL_W      = 16,
    parameter int SCROLL_DIV = 25000000,
    parameter int BLINK_DIV  = 12500000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [1:0]                     mode,
    input  logic                           load,
    input  logic [5*MSG_LEN-1:0]           msg_in,
    input  logic [$clog2(MSG_LEN+1)-1:0]   msg_len_in,
    input  logic [VAL_W-1:0]               val_in,
    input  logic                           lz_blank,
    input  logic                           blink_en,
    output logic                           scroll_wrap,
    output logic [8*NUM_DIGITS-1:0]        hex_out
);

    localparam int LW   = $clog2(MSG_LEN + 1);
    localparam int RMAX = MSG_LEN + NUM_DIGITS;
    localparam int PW   = $clog2(RMAX);
    // pos + digit offset stays below 2*RMAX, so IW bits hold it before the mod
    localparam int IW   = $clog2(2 * RMAX);
    localparam int NN   = (VAL_W + 3) / 4;
    localparam int HD   = (NN > NUM_DIGITS) ? NN : NUM_DIGITS;
    localparam int SW   = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam int BW   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [4:0] CH_BLANK = 5'd25;

    function automatic logic [7:0] seg7(input logic [4:0] c);
        case (c)
            5'd0:    seg7 = 8'hC0;
            5'd1:    seg7 = 8'hF9;
            5'd2:    seg7 = 8'hA4;
            5'd3:    seg7 = 8'hB0;
            5'd4:    seg7 = 8'h99;
            5'd5:    seg7 = 8'h92;
            5'd6:    seg7 = 8'h82;
            5'd7:    seg7 = 8'hF8;
            5'd8:    seg7 = 8'h80;
            5'd9:    seg7 = 8'h90;
            5'd10:   seg7 = 8'h88;
            5'd11:   seg7 = 8'h83;
            5'd12:   seg7 = 8'hC6;
            5'd13:   seg7 = 8'hA1;
            5'd14:   seg7 = 8'h86;
            5'd15:   seg7 = 8'h8E;
            5'd16:   seg7 = 8'hAF;
            5'd17:   seg7 = 8'hA1;
            5'd18:   seg7 = 8'h87;
            5'd19:   seg7 = 8'hF7;
            5'd20:   seg7 = 8'hBF;
            5'd21:   seg7 = 8'hAB;
            5'd22:   seg7 = 8'h7F;
            5'd23:   seg7 = 8'hC7;
            5'd24:   seg7 = 8'hC1;
            default: seg7 = 8'hFF;
        endcase
    endfunction

    logic [4:0]              msg_buf_q [MSG_LEN];
    logic [LW-1:0]           len_q, len_d;
    logic [PW-1:0]           pos_q, pos_d;
    logic [SW-1:0]           scnt_q, scnt_d;
    logic [BW-1:0]           bcnt_q, bcnt_d;
    logic                    bph_q, bph_d;
    logic [1:0]              mode_q;
    logic                    wrap_q, wrap_d;
    logic [8*NUM_DIGITS-1:0] hex_q, hex_d;

    logic [IW-1:0]           len_x;
    logic [IW-1:0]           ring;
    logic                    mode_chg;
    logic                    scroll_act;
    logic                    lz_eff;

    assign scroll_wrap = wrap_q;
    assign hex_out     = hex_q;

    assign len_d      = (msg_len_in > LW'(MSG_LEN)) ? LW'(MSG_LEN) : msg_len_in;
    assign len_x      = IW'(len_q);
    assign ring       = len_x + IW'(NUM_DIGITS);
    assign mode_chg   = (mode != mode_q);
    // A message that fits on the display never scrolls
    assign scroll_act = (mode == 2'd1) && (len_x > IW'(NUM_DIGITS));
    assign lz_eff     = lz_blank || (mode == 2'd3);

    // Scroll position / counter next state
    always_comb begin
        pos_d  = pos_q;
        scnt_d = scnt_q;
        wrap_d = 1'b0;
        if (load || mode_chg || !scroll_act) begin
            pos_d  = '0;
            scnt_d = '0;
        end else if (scnt_q == SW'(SCROLL_DIV - 1)) begin
            scnt_d = '0;
            if (IW'(pos_q) == ring - IW'(1)) begin
                pos_d  = '0;
                wrap_d = 1'b1;
            end else begin
                pos_d = pos_q + PW'(1);
            end
        end else begin
            scnt_d = scnt_q + SW'(1);
        end
    end

    // Blink counter / phase next state
    always_comb begin
        bcnt_d = bcnt_q;
        bph_d  = bph_q;
        if (!blink_en) begin
            bcnt_d = '0;
            bph_d  = 1'b0;
        end else if (bcnt_q == BW'(BLINK_DIV - 1)) begin
            bcnt_d = '0;
            bph_d  = ~bph_q;
        end else begin
            bcnt_d = bcnt_q + BW'(1);
        end
    end

    // Display next state
    logic [IW-1:0]   base;
    logic [IW-1:0]   idx;
    logic [4:0]      ch;
    logic [4*HD-1:0] valx;
    logic [3:0]      nib;
    logic            seen;
    logic [HD-1:0]   hex_blank;
    logic [7:0]      dig;

    always_comb begin
        hex_d     = '1;
        idx       = '0;
        ch        = CH_BLANK;
        nib       = '0;
        seen      = 1'b0;
        hex_blank = '0;
        dig       = 8'hFF;
        base      = (mode == 2'd1) ? IW'(pos_q) : '0;
        valx      = (4*HD)'(val_in);

        // Scan from the top nibble down; anything above the first nonzero is leading
        for (int k = HD - 1; k >= 0; k--) begin
            nib = valx[4*k +: 4];
            if (nib != 4'd0) begin
                seen = 1'b1;
            end
            hex_blank[k] = (k >= NN) || (lz_eff && !seen && (k != 0));
        end

        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (mode[1]) begin
                dig = hex_blank[k] ? 8'hFF : seg7({1'b0, valx[4*k +: 4]});
            end else begin
                idx = base + IW'(NUM_DIGITS - 1 - k);
                if (idx >= ring) begin
                    idx = idx - ring;
                end
                ch = CH_BLANK;
                for (int j = 0; j < MSG_LEN; j++) begin
                    if ((idx == IW'(j)) && (idx < len_x)) begin
                        ch = msg_buf_q[j];
                    end
                end
                dig = seg7(ch);
            end
            if (blink_en && bph_q) begin
                dig = 8'hFF;
            end
            hex_d[8*k +: 8] = dig;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                msg_buf_q[i] <= CH_BLANK;
            end
            len_q  <= '0;
            pos_q  <= '0;
            scnt_q <= '0;
            bcnt_q <= '0;
            bph_q  <= 1'b0;
            mode_q <= 2'd0;
            wrap_q <= 1'b0;
            hex_q  <= '1;
        end else begin
            if (load) begin
                for (int i = 0; i < MSG_LEN; i++) begin
                    msg_buf_q[i] <= msg_in[5*i +: 5];
                end
                len_q <= len_d;
            end
            pos_q  <= pos_d;
            scnt_q <= scnt_d;
            bcnt_q <= bcnt_d;
            bph_q  <= bph_d;
            mode_q <= mode;
            wrap_q <= wrap_d;
            hex_q  <= hex_d;
        end
    end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// tb/tb_hex_display_ctrl.sv - self-checking bench for hex_display_ctrl
module tb_hex_display_ctrl;

    localparam int ND = 6;
    localparam int ML = 16;
    localparam int VW = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0]        mode = 2'd0;
    logic              load = 1'b0;
    logic [5*ML-1:0]   msg_in = '0;
    logic [4:0]        msg_len_in = '0;
    logic [VW-1:0]     val_in = '0;
    logic              lz_blank = 1'b0;
    logic              blink_en = 1'b0;
    logic              scroll_wrap;
    logic [8*ND-1:0]   hex_out;

    int n_tests = 0;
    int n_fail  = 0;

    hex_display_ctrl #(
        .NUM_DIGITS (ND),
        .MSG_LEN    (ML),
        .VAL_W      (VW),
        .SCROLL_DIV (4),
        .BLINK_DIV  (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode),
        .load        (load),
        .msg_in      (msg_in),
        .msg_len_in  (msg_len_in),
        .val_in      (val_in),
        .lz_blank    (lz_blank),
        .blink_en    (blink_en),
        .scroll_wrap (scroll_wrap),
        .hex_out     (hex_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  mode;
        logic        load;
        logic [79:0] msg;
        logic [4:0]  len;
        logic [15:0] val;
        logic        lz;
        logic [47:0] exp;
    } vec_t;

    vec_t vt[14];

    localparam logic [47:0] ALL_FF = 48'hFF_FF_FF_FF_FF_FF;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk48(input string nm, input logic [47:0] act, input logic [47:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", nm, act, exp);
        end
    endtask

    // Six leading characters, the rest of the buffer blank
    function automatic logic [79:0] pk6(input int a, input int b, input int c,
                                        input int d, input int e, input int f);
        logic [79:0] m;
        for (int i = 0; i < ML; i++) m[5*i +: 5] = 5'd25;
        m[4:0]   = 5'(a);
        m[9:5]   = 5'(b);
        m[14:10] = 5'(c);
        m[19:15] = 5'(d);
        m[24:20] = 5'(e);
        m[29:25] = 5'(f);
        return m;
    endfunction

    // Character i holds code i
    function automatic logic [79:0] seq16();
        logic [79:0] m;
        for (int i = 0; i < ML; i++) m[5*i +: 5] = 5'(i);
        return m;
    endfunction

    function automatic logic [7:0] hexseg(input int v);
        case (v)
            0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
            4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
            default: return 8'hFF;
        endcase
    endfunction

    initial begin
        logic [47:0] v_a5;
        logic [7:0]  lead;
        int          p;

        vt[0]  = '{"text_read0",  2'd0, 1'b1, pk6(16,14,10,17,19,0),  5'd6,  16'h0,    1'b0, 48'hAF_86_88_A1_F7_C0};
        vt[1]  = '{"text_len3",   2'd0, 1'b1, pk6(18,21,1,25,25,25),  5'd3,  16'h0,    1'b0, 48'h87_AB_F9_FF_FF_FF};
        vt[2]  = '{"text_clamp",  2'd0, 1'b1, seq16(),                5'd20, 16'h0,    1'b0, 48'hC0_F9_A4_B0_99_92};
        vt[3]  = '{"text_len2",   2'd0, 1'b1, pk6(23,24,7,7,7,7),     5'd2,  16'h0,    1'b0, 48'hC7_C1_FF_FF_FF_FF};
        vt[4]  = '{"text_codes",  2'd0, 1'b1, pk6(20,22,26,31,25,19), 5'd6,  16'h0,    1'b0, 48'hBF_7F_FF_FF_FF_F7};
        vt[5]  = '{"hex_a5",      2'd2, 1'b0, '0,                     5'd0,  16'h00A5, 1'b0, 48'hFF_FF_C0_C0_88_92};
        vt[6]  = '{"hex_a5_lz",   2'd2, 1'b0, '0,                     5'd0,  16'h00A5, 1'b1, 48'hFF_FF_FF_FF_88_92};
        vt[7]  = '{"hex_0_lz",    2'd2, 1'b0, '0,                     5'd0,  16'h0000, 1'b1, 48'hFF_FF_FF_FF_FF_C0};
        vt[8]  = '{"hex_m3",      2'd3, 1'b0, '0,                     5'd0,  16'h0B3C, 1'b0, 48'hFF_FF_FF_83_B0_C6};
        vt[9]  = '{"hex_ffff_lz", 2'd2, 1'b0, '0,                     5'd0,  16'hFFFF, 1'b1, 48'hFF_FF_8E_8E_8E_8E};
        vt[10] = '{"hex_1000_lz", 2'd2, 1'b0, '0,                     5'd0,  16'h1000, 1'b1, 48'hFF_FF_F9_C0_C0_C0};
        vt[11] = '{"hex_0",       2'd2, 1'b0, '0,                     5'd0,  16'h0000, 1'b0, 48'hFF_FF_C0_C0_C0_C0};
        vt[12] = '{"scroll_short",2'd1, 1'b1, pk6(1,2,3,4,25,25),     5'd4,  16'h0,    1'b0, 48'hF9_A4_B0_99_FF_FF};
        vt[13] = '{"text_len0",   2'd0, 1'b1, pk6(1,2,3,4,5,6),       5'd0,  16'h0,    1'b0, ALL_FF};

        // Reset state
        #12;
        chk48("reset_hex", hex_out, ALL_FF);
        chk1("reset_wrap", scroll_wrap, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Load latency: old display on the load edge, new one after the next edge
        mode       = 2'd0;
        load       = 1'b1;
        msg_in     = pk6(16,14,10,17,19,0);
        msg_len_in = 5'd6;
        tick();
        load = 1'b0;
        chk48("load_edge_old", hex_out, ALL_FF);
        tick();
        chk48("load_edge_new", hex_out, 48'hAF_86_88_A1_F7_C0);

        // Table-driven vectors
        for (int i = 0; i < 14; i++) begin
            mode       = vt[i].mode;
            load       = vt[i].load;
            msg_in     = vt[i].msg;
            msg_len_in = vt[i].len;
            val_in     = vt[i].val;
            lz_blank   = vt[i].lz;
            tick();
            load = 1'b0;
            tick();
            chk48(vt[i].name, hex_out, vt[i].exp);
            chk1({vt[i].name, "_wrap"}, scroll_wrap, 1'b0);
        end

        // Scrolling 8 characters "0..7", ring of 14, step every 4 cycles
        lz_blank   = 1'b0;
        mode       = 2'd1;
        load       = 1'b1;
        msg_in     = seq16();
        msg_len_in = 5'd8;
        tick();
        load = 1'b0;
        for (int c = 1; c <= 120; c++) begin
            tick();
            if (((c - 1) % 4) == 0) begin
                p    = ((c - 1) / 4) % 14;
                lead = (p < 8) ? hexseg(p) : 8'hFF;
                chk8("scroll_lead", hex_out[47:40], lead);
            end
            if (c == 33) chk48("scroll_pos8", hex_out, ALL_FF);
            if (c == 41) chk48("scroll_pos10", hex_out, 48'hFF_FF_FF_FF_C0_F9);
            chk1("scroll_wrap", scroll_wrap, (c == 56) || (c == 112));
        end

        // Blink in HEX mode, half-period 3
        v_a5     = 48'hFF_FF_C0_C0_88_92;
        mode     = 2'd2;
        val_in   = 16'h00A5;
        blink_en = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            chk48("blink_seq", hex_out, ((((c - 1) / 3) % 2) == 0) ? v_a5 : ALL_FF);
        end
        blink_en = 1'b0;
        tick();
        chk48("blink_drop", hex_out, v_a5);
        tick();
        chk48("blink_off", hex_out, v_a5);
        blink_en = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk48("blink_restart", hex_out, (c <= 3) ? v_a5 : ALL_FF);
        end
        blink_en = 1'b0;
        tick();

        // Reset mid-scroll (pos 5) with blink phase 1
        mode       = 2'd1;
        load       = 1'b1;
        msg_in     = seq16();
        msg_len_in = 5'd8;
        blink_en   = 1'b1;
        tick();
        load = 1'b0;
        for (int c = 1; c <= 20; c++) tick();
        chk48("pre_reset_pos4", hex_out, 48'h99_92_82_F8_FF_FF);
        rst = 1'b1;
        #1;
        chk48("async_reset_hex", hex_out, ALL_FF);
        chk1("async_reset_wrap", scroll_wrap, 1'b0);
        tick();
        chk48("reset_held_hex", hex_out, ALL_FF);
        rst      = 1'b0;
        mode     = 2'd0;
        blink_en = 1'b0;
        tick();
        chk48("post_reset_blank0", hex_out, ALL_FF);
        tick();
        chk48("post_reset_blank1", hex_out, ALL_FF);
        chk1("post_reset_wrap", scroll_wrap, 1'b0);
        load       = 1'b1;
        msg_in     = pk6(16,14,10,17,19,0);
        msg_len_in = 5'd6;
        tick();
        load = 1'b0;
        tick();
        chk48("post_reset_load", hex_out, 48'hAF_86_88_A1_F7_C0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
